// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and enums for the data memory arbiter slice.
// The arbiter and its round-robin picker import this package.
package data_mem_arbiter_pkg;
  localparam int WORD_SIZE   = 19;
  localparam int DMEM_ADDR_W = 10;

  typedef enum logic {PORT_C, PORT_D} port_id_t;
  typedef enum logic {ARB, DMA_BURST} arb_state_t;
endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between the CPU (C) and DMA (D) ports.
// i_force_c hands C the win on a tie right after a capped DMA burst.
module rr_arb2
  import data_mem_arbiter_pkg::*;
(
  input  logic     i_c_req,
  input  logic     i_d_req,
  input  port_id_t i_last_gnt,
  input  logic     i_force_c,
  output logic     o_gnt_c,
  output logic     o_gnt_d
);
  logic w_pick_c;

  // C wins when alone, when forced, or when D was the last one served.
  assign w_pick_c = i_c_req & (~i_d_req | i_force_c | (i_last_gnt == PORT_D));
  assign o_gnt_c  = w_pick_c;
  assign o_gnt_d  = i_d_req & ~w_pick_c;
endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter and access sequencer sharing a single-ported data memory between
// the CPU load/store port (C) and the DMA/debug port (D), with bounded DMA bursts.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = WORD_SIZE,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_lock,
  output logic              c_ack,
  output logic              d_ack,
  output logic              c_rvalid,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_t        o_dbg_state
);
  localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

  arb_state_t        r_state;
  port_id_t          r_last_gnt;
  logic [3:0]        r_burst_cnt;
  logic              r_force_c;
  logic              r_mem_wr_en;
  logic              r_mem_rd_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_tag0_v;
  port_id_t          r_tag0;
  logic              r_tag1_v;
  port_id_t          r_tag1;

  logic              w_arb_c;
  logic              w_arb_d;
  logic              w_gnt_c;
  logic              w_gnt_d;
  logic              w_gnt;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  port_id_t          w_gnt_port;
  logic [3:0]        w_cnt_next;

  rr_arb2 u_rr_arb2 (
    .i_c_req    (c_req),
    .i_d_req    (d_req),
    .i_last_gnt (r_last_gnt),
    .i_force_c  (r_force_c),
    .o_gnt_c    (w_arb_c),
    .o_gnt_d    (w_arb_d)
  );

  // During a burst D owns the memory; once it stops asking, C may take the slot.
  always_comb begin
    w_gnt_c = 1'b0;
    w_gnt_d = 1'b0;
    if (r_state == DMA_BURST) begin
      w_gnt_d = d_req;
      w_gnt_c = c_req & ~d_req;
    end else begin
      w_gnt_c = w_arb_c;
      w_gnt_d = w_arb_d;
    end
  end

  assign w_gnt      = w_gnt_c | w_gnt_d;
  assign w_gnt_port = w_gnt_d ? PORT_D : PORT_C;
  assign w_we       = w_gnt_d ? d_we    : c_we;
  assign w_addr     = w_gnt_d ? d_addr  : c_addr;
  assign w_wdata    = w_gnt_d ? d_wdata : c_wdata;
  assign w_cnt_next = (r_state == ARB) ? 4'd1 : r_burst_cnt + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB;
      r_last_gnt  <= PORT_D;
      r_burst_cnt <= 4'd0;
      r_force_c   <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag0_v    <= 1'b0;
      r_tag0      <= PORT_C;
      r_tag1_v    <= 1'b0;
      r_tag1      <= PORT_C;
    end else begin
      r_mem_wr_en <= w_gnt & w_we;
      r_mem_rd_en <= w_gnt & ~w_we;
      if (w_gnt) begin
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_wdata;
        r_last_gnt  <= w_gnt_port;
      end
      r_tag0_v  <= w_gnt & ~w_we;
      r_tag0    <= w_gnt_port;
      r_tag1_v  <= r_tag0_v;
      r_tag1    <= r_tag0;
      r_force_c <= 1'b0;

      // Burst entry, continuation and the three exit paths share one decision.
      if (w_gnt_d && (r_state == DMA_BURST || d_lock)) begin
        if (!d_lock) begin
          r_state     <= ARB;
          r_burst_cnt <= 4'd0;
        end else if (w_cnt_next == LP_MAX_BURST) begin
          r_state     <= ARB;
          r_burst_cnt <= 4'd0;
          r_force_c   <= 1'b1;
        end else begin
          r_state     <= DMA_BURST;
          r_burst_cnt <= w_cnt_next;
        end
      end else if (r_state == DMA_BURST) begin
        r_state     <= ARB;
        r_burst_cnt <= 4'd0;
      end
    end
  end

  assign c_ack       = w_gnt_c;
  assign d_ack       = w_gnt_d;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign c_rvalid    = r_tag1_v & (r_tag1 == PORT_C);
  assign d_rvalid    = r_tag1_v & (r_tag1 == PORT_D);
  assign c_rdata     = c_rvalid ? mem_rdata : '0;
  assign d_rdata     = d_rvalid ? mem_rdata : '0;
  assign o_dbg_state = r_state;
endmodule
